// File: rtl/hazard_sched_if.sv
// Hazard scheduler bus: ID/EX/MEM register fields in, pipeline control out.
//
// Handshake: none. Every signal is a level that is valid for the whole
// cycle; the master presents pipeline fields and samples the control
// outputs combinationally in the same cycle, and the effect of the controls
// lands on the next rising clock edge.
interface hazard_sched_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_usesRt;
  logic             ID_branch;
  logic             ID_branch_taken;
  logic             ID_jump;
  logic             EX_memread;
  logic             EX_regwrite;
  logic [REG_W-1:0] EX_dst;
  logic             MEM_memread;
  logic [REG_W-1:0] MEM_Rt;
  logic             pc_write;
  logic             IF_ID_write;
  logic             flush_ID_EX;
  logic             flush_IF_ID;
  logic             stall_active;

  // Pipeline side: drives register fields, consumes control.
  modport master (
    output ID_Rs, ID_Rt, ID_usesRt, ID_branch, ID_branch_taken, ID_jump,
           EX_memread, EX_regwrite, EX_dst, MEM_memread, MEM_Rt,
    input  pc_write, IF_ID_write, flush_ID_EX, flush_IF_ID, stall_active
  );

  // Scheduler side.
  modport slave (
    input  ID_Rs, ID_Rt, ID_usesRt, ID_branch, ID_branch_taken, ID_jump,
           EX_memread, EX_regwrite, EX_dst, MEM_memread, MEM_Rt,
    output pc_write, IF_ID_write, flush_ID_EX, flush_IF_ID, stall_active
  );
endinterface

// File: rtl/hazard_sched.sv
// Hazard scheduler for the 5-stage pipeline. Detects load-use and
// branch-operand hazards, sequences multi-cycle stalls (RUN/HOLD FSM) and
// issues IF/ID flushes for taken branches and jumps.
// Optional build macro HAZARD_STATS_EN adds saturating stall/flush counters.
// stall_active mirrors the FSM state (1 = HOLD) for observation.
module hazard_sched #(
  parameter int REG_W     = 5,
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  hazard_sched_if.slave    hz
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_e;

  state_e               state_q, state_d;
  logic [MAX_STALL-1:0] rem_q, rem_d;
  logic [MAX_STALL-1:0] need_n;
  logic                 ex_hit;
  logic                 mem_hit;

  // A producer register matches when it is non-zero and is read by ID.
  function automatic logic srcmatch(input logic [REG_W-1:0] x,
                                    input logic [REG_W-1:0] rs,
                                    input logic [REG_W-1:0] rt,
                                    input logic             uses_rt);
    return (x != '0) && ((x == rs) || (uses_rt && (x == rt)));
  endfunction

  // Hazard detection: required stall length, largest applicable wins.
  always_comb begin
    ex_hit  = srcmatch(hz.EX_dst, hz.ID_Rs, hz.ID_Rt, hz.ID_usesRt);
    mem_hit = srcmatch(hz.MEM_Rt, hz.ID_Rs, hz.ID_Rt, hz.ID_usesRt);
    need_n  = '0;
    if (!hz.ID_branch && hz.EX_memread && ex_hit)
      need_n = MAX_STALL'(1);
    if (hz.ID_branch && hz.MEM_memread && mem_hit)
      need_n = MAX_STALL'(1);
    if (hz.ID_branch && hz.EX_regwrite && !hz.EX_memread && ex_hit)
      need_n = MAX_STALL'(1);
    // Branches compare in ID, so a load still in EX needs two bubbles.
    if (hz.ID_branch && hz.EX_memread && ex_hit)
      need_n = MAX_STALL'(2);
  end

  // State and remaining-stall register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next state and pipeline controls; outputs are combinational.
  always_comb begin
    state_d         = state_q;
    rem_d           = rem_q;
    hz.pc_write     = 1'b1;
    hz.IF_ID_write  = 1'b1;
    hz.flush_ID_EX  = 1'b0;
    hz.flush_IF_ID  = 1'b0;
    hz.stall_active = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (need_n != '0) begin
          // First stall cycle; a pending branch/jump flush waits for release.
          hz.pc_write    = 1'b0;
          hz.IF_ID_write = 1'b0;
          hz.flush_ID_EX = 1'b1;
          if (need_n >= MAX_STALL'(2)) begin
            state_d = ST_HOLD;
            rem_d   = need_n - MAX_STALL'(1);
          end
        end else begin
          hz.flush_IF_ID = (hz.ID_branch && hz.ID_branch_taken) || hz.ID_jump;
        end
      end
      ST_HOLD: begin
        // Inputs ignored; keep bubbling until the count runs out.
        hz.pc_write     = 1'b0;
        hz.IF_ID_write  = 1'b0;
        hz.flush_ID_EX  = 1'b1;
        hz.stall_active = 1'b1;
        if (rem_q <= MAX_STALL'(1)) begin
          state_d = ST_RUN;
          rem_d   = '0;
        end else begin
          rem_d = rem_q - MAX_STALL'(1);
        end
      end
      default: begin
        state_d = ST_RUN;
        rem_d   = '0;
      end
    endcase
  end

`ifdef HAZARD_STATS_EN
  // Saturating statistics: stalled cycles and IF/ID flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (!hz.pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (hz.flush_IF_ID && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`else
  // Counter width only matters when statistics are built in.
  if (CNT_W < 1) begin : g_cnt_w_unused
  end
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Directed bench for hazard_sched: a table of single-cycle vectors plus
// hand-written sequences for the two-cycle branch stall, jump+load-use,
// reset during HOLD and (with HAZARD_STATS_EN) counter saturation.
module tb_hazard_sched;
  localparam int REG_W = 5;
`ifdef HAZARD_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  hazard_sched_if #(.REG_W(REG_W)) hz ();

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
`endif

  hazard_sched #(.REG_W(REG_W), .CNT_W(CNT_W), .MAX_STALL(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz.slave)
`ifdef HAZARD_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, br, taken, jmp, ex_mr, ex_rw;
    logic [4:0] ex_dst;
    logic       mem_mr;
    logic [4:0] mem_rt;
    logic       pw, iw, fe, ff, sa;
  } vec_t;

  vec_t vecs[$];

  // Driver tasks
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic uses_rt, input logic br, input logic taken,
                       input logic jmp, input logic ex_mr, input logic ex_rw,
                       input logic [4:0] ex_dst, input logic mem_mr,
                       input logic [4:0] mem_rt);
    hz.ID_Rs           = rs;
    hz.ID_Rt           = rt;
    hz.ID_usesRt       = uses_rt;
    hz.ID_branch       = br;
    hz.ID_branch_taken = taken;
    hz.ID_jump         = jmp;
    hz.EX_memread      = ex_mr;
    hz.EX_regwrite     = ex_rw;
    hz.EX_dst          = ex_dst;
    hz.MEM_memread     = mem_mr;
    hz.MEM_Rt          = mem_rt;
  endtask

  task automatic add_vec(input string name, input logic [4:0] rs,
                         input logic [4:0] rt, input logic uses_rt,
                         input logic br, input logic taken, input logic jmp,
                         input logic ex_mr, input logic ex_rw,
                         input logic [4:0] ex_dst, input logic mem_mr,
                         input logic [4:0] mem_rt, input logic pw,
                         input logic iw, input logic fe, input logic ff,
                         input logic sa);
    vec_t v;
    v.name = name; v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.br = br;
    v.taken = taken; v.jmp = jmp; v.ex_mr = ex_mr; v.ex_rw = ex_rw;
    v.ex_dst = ex_dst; v.mem_mr = mem_mr; v.mem_rt = mem_rt;
    v.pw = pw; v.iw = iw; v.fe = fe; v.ff = ff; v.sa = sa;
    vecs.push_back(v);
  endtask

  // Scoreboard: one comparison against a bench-computed expectation.
  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare all five control outputs against an expected tuple.
  task automatic chk_ctl(input string name, input logic pw, input logic iw,
                         input logic fe, input logic ff, input logic sa);
    chk({name, ".pc_write"},     32'(hz.pc_write),     32'(pw));
    chk({name, ".IF_ID_write"},  32'(hz.IF_ID_write),  32'(iw));
    chk({name, ".flush_ID_EX"},  32'(hz.flush_ID_EX),  32'(fe));
    chk({name, ".flush_IF_ID"},  32'(hz.flush_IF_ID),  32'(ff));
    chk({name, ".stall_active"}, 32'(hz.stall_active), 32'(sa));
  endtask

  // Move to the middle of a cycle: after the negedge, away from posedge.
  task automatic mid_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    #1;
    chk_ctl("reset", 1, 1, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    chk("reset.stall_cycles", 32'(stall_cycles), 0);
    chk("reset.flush_count",  32'(flush_count),  0);
`endif
    mid_cycle();
    rst_n = 1'b1;

    //        name            rs rt u br tk j  exm exw exd mm mrt  pw iw fe ff sa
    add_vec("idle",           0, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0,  1, 1, 0, 0, 0);
    add_vec("lw_use_rs",      8, 0, 0, 0, 0, 0, 1,  1,  8,  0, 0,  0, 0, 1, 0, 0);
    add_vec("lw_dst0",        0, 0, 0, 0, 0, 0, 1,  1,  0,  0, 0,  1, 1, 0, 0, 0);
    add_vec("beq_alu_rt",     3, 5, 1, 1, 0, 0, 0,  1,  5,  0, 0,  0, 0, 1, 0, 0);
    add_vec("beq_alu_rt_nu",  3, 5, 0, 1, 0, 0, 0,  1,  5,  0, 0,  1, 1, 0, 0, 0);
    add_vec("jump_clean",     0, 0, 0, 0, 0, 1, 0,  0,  0,  0, 0,  1, 1, 0, 1, 0);
    add_vec("beq_taken",      1, 2, 1, 1, 1, 0, 0,  1,  7,  0, 0,  1, 1, 0, 1, 0);
    add_vec("taken_no_br",    1, 2, 1, 0, 1, 0, 0,  0,  0,  0, 0,  1, 1, 0, 0, 0);
    add_vec("beq_mem_load",   7, 2, 1, 1, 1, 0, 0,  0,  0,  1, 7,  0, 0, 1, 0, 0);
    add_vec("alu_mem_load",   7, 2, 1, 0, 0, 0, 0,  0,  0,  1, 7,  1, 1, 0, 0, 0);
    add_vec("alu_ex_alu",     4, 2, 1, 0, 0, 0, 0,  1,  4,  0, 0,  1, 1, 0, 0, 0);
    add_vec("lw_rt_unused",   2, 6, 0, 0, 0, 0, 1,  1,  6,  0, 0,  1, 1, 0, 0, 0);
    add_vec("lw_rt_used",     2, 6, 1, 0, 0, 0, 1,  1,  6,  0, 0,  0, 0, 1, 0, 0);
    add_vec("beq_mem_r0",     0, 0, 1, 1, 1, 0, 0,  0,  0,  1, 0,  1, 1, 0, 1, 0);

    // Table-driven single-cycle vectors (none of these enters HOLD).
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].br,
            vecs[i].taken, vecs[i].jmp, vecs[i].ex_mr, vecs[i].ex_rw,
            vecs[i].ex_dst, vecs[i].mem_mr, vecs[i].mem_rt);
      #1;
      chk_ctl(vecs[i].name, vecs[i].pw, vecs[i].iw, vecs[i].fe, vecs[i].ff,
              vecs[i].sa);
      mid_cycle();
    end

    // lw then dependent add: exactly one stall cycle, then release.
    drive(8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0);
    #1 chk_ctl("lw_seq.c0", 0, 0, 1, 0, 0);
    mid_cycle();
    drive(8, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8);   // lw moved to MEM, bubble in EX
    #1 chk_ctl("lw_seq.c1", 1, 1, 0, 0, 0);
    mid_cycle();

    // beq on a load still in EX: RUN stall, HOLD stall, then taken flush.
    drive(9, 0, 0, 1, 1, 0, 1, 1, 9, 0, 0);
    #1 chk_ctl("beq_lw.c0", 0, 0, 1, 0, 0);
    mid_cycle();
    // In HOLD the inputs are ignored, even a jump in ID.
    drive(9, 0, 0, 1, 1, 1, 0, 0, 0, 1, 9);
    #1 chk_ctl("beq_lw.c1_hold", 0, 0, 1, 0, 1);
    mid_cycle();
    drive(9, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    #1 chk_ctl("beq_lw.c2_release", 1, 1, 0, 1, 0);
    mid_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk_ctl("beq_lw.c3", 1, 1, 0, 0, 0);
    mid_cycle();

    // Jump plus load-use: stall first, jump flush on release.
    drive(4, 0, 0, 0, 0, 1, 1, 1, 4, 0, 0);
    #1 chk_ctl("jmp_lw.c0", 0, 0, 1, 0, 0);
    mid_cycle();
    drive(4, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4);
    #1 chk_ctl("jmp_lw.c1", 1, 1, 0, 1, 0);
    mid_cycle();

    // Reset asserted while in HOLD returns to RUN immediately.
    drive(9, 0, 0, 1, 0, 0, 1, 1, 9, 0, 0);
    mid_cycle();
    #1 chk_ctl("rst_hold.pre", 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1 chk_ctl("rst_hold.async", 1, 1, 0, 0, 0);
`ifdef HAZARD_STATS_EN
    chk("rst_hold.stall_cycles", 32'(stall_cycles), 0);
    chk("rst_hold.flush_count",  32'(flush_count),  0);
`endif
    mid_cycle();
    rst_n = 1'b1;
    mid_cycle();
    #1 chk_ctl("rst_hold.after", 1, 1, 0, 0, 0);

`ifdef HAZARD_STATS_EN
    // Saturation: 20 stalled cycles into a 4-bit counter, then 3 jumps.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0);
    for (int c = 0; c < 20; c++) mid_cycle();
    chk("stats.stall_cycles_sat", 32'(stall_cycles), 32'hF);
    chk("stats.flush_count_idle", 32'(flush_count), 0);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) mid_cycle();
    chk("stats.flush_count_3", 32'(flush_count), 3);
    chk("stats.stall_hold", 32'(stall_cycles), 32'hF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
